// File: rtl/pattern_serializer_pkg.sv
// Shared types and default sizes for the pattern serializer and its benches.
package pattern_serializer_pkg;

  // Default maximum pattern length in bits.
  localparam int PAT_W_DEF = 8;
  // Default width of the repetition count.
  localparam int REP_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } ser_state_t;

endpackage

// File: rtl/pattern_serializer_wrap_counter.sv
// Up-counter that wraps to zero when it steps past a runtime terminal value.
// Synchronous clear has priority over enable.
module wrap_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         tc
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign count = count_q;
  assign tc    = (count_q == term);

  // Next count: clear, wrap at terminal, or step by one when enabled.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = tc ? '0 : count_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pattern_serializer.sv
// Programmable serial bit-stream transmitter: sends pattern[len-1:0] MSB-first,
// reps times back-to-back (or continuously when reps is 0) until stopped.
module pattern_serializer
  import pattern_serializer_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int REP_W = REP_W_DEF,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] reps,
  input  logic             stop,
  output logic             seq,
  output logic             seq_valid,
  output logic             busy,
  output logic             done
);

  ser_state_t       state_q, state_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [REP_W-1:0] reps_q, reps_d;
  logic             seq_q, seq_d;
  logic             seq_valid_q, seq_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [LEN_W-1:0] len_clamped;
  logic             accept;
  logic             bit_en;
  logic             rep_en;
  logic [LEN_W-1:0] idx;
  logic [LEN_W-1:0] idx_nxt;
  logic             bit_tc;
  logic [REP_W-1:0] rep_cnt;
  logic             rep_tc;
  logic             last_rep;
  logic [PAT_W-1:0] src_pat;
  logic [LEN_W-1:0] src_sel;
  logic [PAT_W-1:0] bit_hit;
  logic             picked;
  logic             unused_ok;

  // Requests longer than the pattern register are truncated to its width.
  assign len_clamped = (len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len;
  assign accept      = (state_q == IDLE) && start && (len != '0);

  // Advance only while actually emitting bits; an abort freezes the counters.
  assign bit_en   = (state_q == SEND) && !stop;
  assign rep_en   = bit_en && bit_tc;
  assign last_rep = bit_tc && rep_tc && (reps_q != '0);

  // Bit index within the current repetition (index of the bit now on seq).
  wrap_counter #(
    .W (LEN_W)
  ) u_bit_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (bit_en),
    .clr   (accept),
    .term  (len_q - LEN_W'(1)),
    .count (idx),
    .tc    (bit_tc)
  );

  // Repetition counter; wraps harmlessly in continuous mode (reps_q == 0).
  wrap_counter #(
    .W (REP_W)
  ) u_rep_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (rep_en),
    .clr   (accept),
    .term  (reps_q - REP_W'(1)),
    .count (rep_cnt),
    .tc    (rep_tc)
  );

  // Only the terminal flag of the repetition counter drives decisions.
  assign unused_ok = ^rep_cnt;

  // Index of the bit that goes out next: the MSB of the new request on
  // acceptance, otherwise the following bit of the captured pattern.
  assign idx_nxt = bit_tc ? '0 : idx + LEN_W'(1);
  assign src_pat = accept ? pattern : pattern_q;
  assign src_sel = accept ? (len_clamped - LEN_W'(1))
                          : (len_q - LEN_W'(1) - idx_nxt);

  // One-hot bit select avoids an index wider than the pattern register.
  for (genvar gi = 0; gi < PAT_W; gi++) begin : g_pick
    assign bit_hit[gi] = src_pat[gi] & (src_sel == LEN_W'(gi));
  end
  assign picked = |bit_hit;

  // Next-state and next-output logic for the transmit FSM.
  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    reps_d    = reps_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          pattern_d = pattern;
          len_d     = len_clamped;
          reps_d    = reps;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (stop || last_rep) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    seq_valid_d = (state_d == SEND);
    seq_d       = seq_valid_d & picked;
    done_d      = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State, captured request and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pattern_q   <= '0;
      len_q       <= '0;
      reps_q      <= '0;
      seq_q       <= 1'b0;
      seq_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      len_q       <= len_d;
      reps_q      <= reps_d;
      seq_q       <= seq_d;
      seq_valid_q <= seq_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign seq       = seq_q;
  assign seq_valid = seq_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/pattern_serializer.md
# pattern_serializer

Programmable serial bit-stream transmitter, the sending end of the single-bit sequence interface consumed by `sequence_detector`. A pattern of 1..PAT_W bits is loaded on a start pulse. It is shifted out MSB-first on `seq`, one bit per clock, and repeated a set number of times or until stopped. Benches and future top levels use it as the runtime-configurable source for `sequence_detector` input `x`.

## Interface
Parameters:
- `PAT_W`, 8: maximum pattern length in bits.
- `REP_W`, 4: width of the repetition count.
- `LEN_W`, $clog2(PAT_W+1): width of `len` (derived, not overridden).

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; latches `pattern`, `len`, `reps`.
- `pattern`  in  PAT_W  bits to send; active field is `pattern[len-1:0]`.
- `len`  in  LEN_W  number of bits per repetition.
- `reps`  in  REP_W  repetitions to send; 0 = continuous until `stop`.
- `stop`  in  1  abort request; acts only while sending.
- `seq`  out  1  serial data bit; 0 whenever `seq_valid` is 0.
- `seq_valid`  out  1  `seq` carries a pattern bit this cycle.
- `busy`  out  1  high in SEND and DONE; `start` is ignored while high.
- `done`  out  1  one-cycle pulse after the last bit or after an abort.

## Operation
- Reset value of every output is 0. On reset, state goes to IDLE and the bit index, repetition counter and captured registers all go to 0.
- States and transitions:
  - IDLE: if `start` is high and `len` != 0, capture the inputs and go to SEND. If `start` is high and `len` == 0, ignore the request and stay in IDLE.
  - SEND: drive `seq` = captured `pattern[len_q-1-idx]` and `seq_valid` = 1.
    - When idx == len_q-1, reset idx to 0 and increment `rep_cnt`.
    - If `reps_q` != 0 and the new `rep_cnt` == `reps_q`, go to DONE. Otherwise keep sending, with no gap cycle between repetitions.
  - DONE: `done` = 1 and `seq_valid` = 0 for exactly one cycle, then go to IDLE.
- `len` > PAT_W is clamped to PAT_W at capture time.
- `stop`:
  - Sampled high in SEND: go to DONE at that edge. The bit that would have followed is not sent.
  - Sampled high in IDLE or DONE: no effect.
- `start` and `stop` high together in IDLE: `start` is accepted and `stop` is ignored.
- `start` while `busy`: ignored. The captured values are not disturbed.
- `rep_cnt` is REP_W bits wide and never wraps in counted mode. In continuous mode (`reps_q` == 0) it wraps freely and the wrap is ignored.

## Timing
- All outputs are registered.
- `start` accepted at edge k:
  - First bit (`pattern[len-1]`) is valid in the cycle after edge k.
  - Bit n (0-based) is valid in the cycle after edge k+n.
- Counted run (L = len, R = reps): exactly L*R consecutive `seq_valid` cycles, `done` in the cycle immediately after the last bit, `busy` falls one cycle after `done`.
- Earliest next accepted `start` is the cycle in which `busy` = 0, i.e. two cycles after the last bit.
- `stop` sampled at edge m in SEND: `seq_valid` = 0 and `done` = 1 in the cycle after edge m.
- `reset` asserted at any time (including mid-SEND):
  - `seq`, `seq_valid`, `busy` and `done` go to 0 immediately.
  - No `done` pulse is generated for the aborted run.
  - Operation resumes only with a new `start` after `reset` is released.

## Structure
- `pattern_serializer_pkg` contains:
  - `typedef enum logic [1:0] {IDLE, SEND, DONE} ser_state_t`.
  - Default `PAT_W` and `REP_W` constants shared with benches.
- Sub-module `wrap_counter`: parameterised width, enable, synchronous clear, terminal-count flag, async active-high `reset`. Instantiated twice: once for the bit index, once for the repetition count.

## Test plan
- Reset held 2 cycles, then released -> `seq`, `seq_valid`, `busy` and `done` all 0; `start` with `len` = 0 -> no `busy`.
- `pattern` = 8'h0B, `len` = 4, `reps` = 1 -> `seq` = 1,0,1,1 over 4 consecutive valid cycles, `done` on the 5th cycle, `busy` low on the 6th.
- `pattern` = 8'hA5, `len` = 8, `reps` = 3 -> 24 contiguous valid bits repeating 10100101, exactly one `done` pulse.
- `reps` = 0, `pattern` = 8'h03, `len` = 2, `stop` asserted after 7 bits -> bits 1,1,... 7 times, then `done`, then IDLE.
- `start` pulsed mid-run with different `pattern`/`len` -> ignored, original stream unchanged; `len` = 12 with PAT_W = 8 -> 8 bits sent.
- `reset` asserted during bit 2 of a 4-bit run -> outputs 0 at once, no `done`; a new `start` afterwards produces a clean full sequence.
